// File: rtl/proc_pkg.sv
// Shared processor constants and types for the execute-stage multiply/divide sequencer.
package proc_pkg;

  localparam logic [4:0] OPC_RTYPE   = 5'b00000;
  localparam logic [4:0] ALU_MUL     = 5'b00110;
  localparam logic [4:0] ALU_DIV     = 5'b00111;
  localparam logic [4:0] RSTATUS_REG = 5'd30;

  localparam logic [31:0] EXC_MUL = 32'd4;
  localparam logic [31:0] EXC_DIV = 32'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Operation context captured at launch and held for the whole BUSY phase.
  typedef struct packed {
    logic        isDiv;
    logic [4:0]  rd;
    logic [31:0] opA;
    logic [31:0] opB;
  } md_ctx_t;

  function automatic logic isMdOp(input logic [4:0] opcode, input logic [4:0] aluOp);
    return (opcode == OPC_RTYPE) && ((aluOp == ALU_MUL) || (aluOp == ALU_DIV));
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_counter.sv
// Saturating BUSY-cycle counter; flags expiry one cycle before the timeout limit.
module md_timeout_counter #(
  parameter int TIMEOUT = 40,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          expired
);

  localparam logic [CW-1:0] COUNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != COUNT_MAX)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == COUNT_LAST);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage sequencer for the multi-cycle multiply/divide unit: launch, hold, stall,
// and emit exactly one writeback (result or exception code) per launched operation.
module multdiv_issue_ctrl
  import proc_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] insn_x,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic        flush,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  md_state_t state;
  md_state_t stateNext;
  md_ctx_t   ctx;

  logic          insnIsMd;
  logic          insnIsDiv;
  logic          launch;
  logic          finish;
  logic          expired;
  logic [CW-1:0] mdCount;
  logic          unusedBits;

  assign insnIsMd  = isMdOp(insn_x[31:27], insn_x[6:2]);
  assign insnIsDiv = (insn_x[6:2] == ALU_DIV);
  assign launch    = (state == IDLE) && insnIsMd && !flush;
  assign finish    = (state == BUSY) && (stateNext == DONE);

  // Only opcode, rd and ALU op matter here; the counter value is observed through expired.
  assign unusedBits = ^{insn_x[21:7], insn_x[1:0], mdCount};

  md_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) uTimeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (launch),
    .enable  (state == BUSY),
    .count   (mdCount),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Flush outranks both a returning result and the timeout.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (launch) stateNext = BUSY;
      end
      BUSY: begin
        if (flush)                     stateNext = IDLE;
        else if (md_ready || expired)  stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ctrl_mult    = 1'b0;
    ctrl_div     = 1'b0;
    stall        = 1'b0;
    busy         = 1'b0;
    md_operand_a = ctx.opA;
    md_operand_b = ctx.opB;
    unique case (state)
      IDLE: begin
        md_operand_a = data_a;
        md_operand_b = data_b;
        stall        = launch;
        ctrl_mult    = launch && !insnIsDiv;
        ctrl_div     = launch && insnIsDiv;
      end
      BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctx      <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (launch) begin
        ctx.isDiv <= insnIsDiv;
        ctx.rd    <= insn_x[26:22];
        ctx.opA   <= data_a;
        ctx.opB   <= data_b;
      end
      // A timeout arrives here without md_ready and is reported like a unit exception.
      if (finish) begin
        wb_valid <= 1'b1;
        if (md_ready && !md_exception) begin
          wb_rd   <= ctx.rd;
          wb_data <= md_result;
        end else begin
          wb_rd   <= RSTATUS_REG;
          wb_data <= ctx.isDiv ? EXC_DIV : EXC_MUL;
        end
      end
    end
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

Sequencer for the multi-cycle multiplier/divider in the execute stage. Detects R-type `mul`/`div` in X, launches the unit with a one-cycle start pulse, and holds operands stable. Stalls F/D/X until the unit finishes or times out, then presents exactly one writeback: the product or quotient to `rd`, or the exception code to `$rstatus` (r30).

## Interface
- `TIMEOUT`, 40: maximum BUSY cycles before a forced exception; legal range is 2..255.
- `clock  in  1`: sole clock; all state updates on the rising edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `insn_x  in  32`: instruction currently in X.
  - Opcode is `insn_x[31:27]`; `rd` is `[26:22]`; ALU op is `[6:2]`.
- `data_a  in  32`: X-stage operand A from bypass.
- `data_b  in  32`: X-stage operand B from bypass.
- `flush  in  1`: squash X-stage work; aborts any in-flight operation.
- `md_ready  in  1`: unit result valid; sampled only in BUSY.
- `md_exception  in  1`: unit exception; qualified by `md_ready`.
- `md_result  in  32`: unit result; qualified by `md_ready`.
- `ctrl_mult  out  1`: one-cycle start pulse for multiply.
- `ctrl_div  out  1`: one-cycle start pulse for divide.
- `md_operand_a  out  32`: operand A to the unit.
- `md_operand_b  out  32`: operand B to the unit.
- `stall  out  1`: hold PC, F/D and D/X latches.
- `busy  out  1`: high in BUSY.
- `wb_valid  out  1`: one-cycle writeback strobe.
- `wb_rd  out  5`: writeback register.
- `wb_data  out  32`: writeback value.

## Operation
- Decode: `md_op` = (opcode == 5'b00000) && (ALU op == 5'b00110 mul or 5'b00111 div).
- States are IDLE, BUSY and DONE. The reset state is IDLE.
- IDLE:
  - If `md_op` and not `flush`, assert `ctrl_mult` or `ctrl_div` combinationally that cycle.
  - Drive `md_operand_a/b` = `data_a/b` combinationally.
  - Assert `stall`.
  - Latch operands, `rd`, the op kind, and clear the counter.
  - Next state is BUSY.
  - If `md_op` is false, or `flush` is high, there is no start and no stall.
- BUSY:
  - `stall` = 1, `busy` = 1; `md_operand_a/b` come from the latched copies.
  - Counter increments each cycle.
  - `md_ready` = 1: capture `md_result` and `md_exception`; go to DONE.
  - Counter == `TIMEOUT-1` with no `md_ready`: force exception; go to DONE.
  - `flush` = 1: go to IDLE with no writeback. `flush` has priority over `md_ready` and over timeout.
- DONE:
  - `stall` = 0; `wb_valid` = 1; next state is IDLE unconditionally.
  - The instruction in X advances on this edge. `insn_x` is ignored in DONE, so the same instruction is never relaunched.
- Writeback values:
  - No exception: `wb_rd` = latched `rd`, `wb_data` = captured result.
  - Exception: `wb_rd` = 5'd30, `wb_data` = 32'd4 for mul, 32'd5 for div.
  - `rd` == 0 with no exception: `wb_valid` still pulses with `wb_rd` = 0; the regfile discards the write.
- `ctrl_mult` and `ctrl_div` are never both high. Neither is asserted outside IDLE.
- Counter width is `$clog2(TIMEOUT+1)` and it saturates; it is not reused across operations.

## Timing
- Reset values:
  - State is IDLE; counter, latched operands, `rd` and result are 0.
  - `stall`, `busy`, `wb_valid`, `ctrl_mult` and `ctrl_div` are 0.
  - `wb_rd` and `wb_data` are 0.
  - `md_operand_a/b` follow `data_a/b`, since the block is in IDLE.
- Launch happens in cycle 0. The unit raises `md_ready` in BUSY cycle N, where N ≥ 1 after launch. DONE is cycle N+1.
- `stall` is high for cycles 0..N, i.e. N+1 cycles. `wb_valid` is high in cycle N+1 only.
- Timeout: `wb_valid` with the exception code occurs in cycle TIMEOUT+1.
- `md_ready` asserted in the launch cycle is ignored.
- Back-to-back: a second `mul`/`div` reaches X in the cycle after DONE and launches then, so there is no dead cycle beyond DONE.
- `reset_n` low in any state returns the block to IDLE on that edge, with all outputs at reset values the next cycle. No writeback is emitted.
- `wb_*` outputs are registered.
- `stall`, `ctrl_*` and `md_operand_*` are combinational from state and `insn_x`.

## Structure
- Shared package `proc_pkg`:
  - Opcode constant R-type 5'b00000.
  - ALU op constants MUL 5'b00110 and DIV 5'b00111.
  - `RSTATUS_REG` = 5'd30.
  - Exception codes `EXC_MUL` = 4 and `EXC_DIV` = 5.
  - `md_state_t` enum: IDLE, BUSY, DONE.
- One sub-module is natural: `md_timeout_counter`.
  - Ports: clear, enable, saturating count, and `expired` at `TIMEOUT-1`.
- Decode and FSM stay in the top module.

## Test plan
- Multiply: `mul r5,r1,r2`, `data_a`=7, `data_b`=6, `md_ready` at N=3 with result 42 → `ctrl_mult` pulses in cycle 0, `stall` high in cycles 0–3, `wb_valid` in cycle 4 with `wb_rd`=5 and `wb_data`=42.
- Divide by zero: `div r9,r3,r4` with `md_exception`=1 at N=2 → `wb_rd`=30, `wb_data`=5, `stall` 3 cycles.
- Timeout: `TIMEOUT`=8, `mul`, `md_ready` never asserted → `wb_valid` in cycle 9 with `wb_rd`=30 and `wb_data`=4; `stall` deasserts in cycle 9.
- Back-to-back with operand hold: two consecutive `mul` with N=1 each → two `ctrl_mult` pulses 3 cycles apart and two `wb_valid` strobes. `md_operand_a/b` stay constant through BUSY while `data_a/b` toggle.
- Flush mid-BUSY: `flush` in BUSY cycle 2 with `md_ready` also high → next state IDLE, no `wb_valid`, `stall` low the next cycle.
- Reset mid-BUSY: `reset_n` low in cycle 2 → all outputs 0 the next cycle, no writeback, and a fresh `div` launches normally after release.
